// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and requester encoding for the writeback arbiter
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - two-way round-robin grant with pointer updated on contention only
module rr_arbiter
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_alu,
    input  logic req_lsu,
    output logic grant_alu,
    output logic grant_lsu
);

    req_t prio;

    always_comb begin
        grant_alu = rst_n && req_alu && (!req_lsu || prio == REQ_ALU);
        grant_lsu = rst_n && req_lsu && (!req_alu || prio == REQ_LSU);
    end

    // Pointer names the requester that wins the next contended cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio <= REQ_ALU;
        end else if (req_alu && req_lsu) begin
            prio <= (prio == REQ_ALU) ? REQ_LSU : REQ_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/LSU writeback arbiter with register-busy scoreboard
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  lsu_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    output logic                  issue_stall,
    output logic                  rf_input_enable,
    output logic [REG_ADDR_W-1:0] rf_input_select,
    output logic [XLEN-1:0]       rf_input_value,
    output logic [NUM_REGS-1:0]   busy
);

    logic                  grant_alu;
    logic                  grant_lsu;
    logic                  accept;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  wr_en_q;
    logic                  issue_fire;
    logic [NUM_REGS-1:0]   busy_next;

    rr_arbiter u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_alu   (alu_valid),
        .req_lsu   (lsu_valid),
        .grant_alu (grant_alu),
        .grant_lsu (grant_lsu)
    );

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;
    assign accept    = grant_alu || grant_lsu;
    assign wb_rd     = grant_alu ? alu_rd   : lsu_rd;
    assign wb_data   = grant_alu ? alu_data : lsu_data;

    // A write staged just before reset asserts must not reach the register file.
    assign rf_input_enable = wr_en_q && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q         <= 1'b0;
            rf_input_select <= '0;
            rf_input_value  <= '0;
        end else begin
            wr_en_q <= accept && (wb_rd != '0);
            if (accept && (wb_rd != '0)) begin
                rf_input_select <= wb_rd;
                rf_input_value  <= wb_data;
            end
        end
    end

    assign issue_stall = !rst_n ||
                         (issue_valid && (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd]));
    assign issue_fire  = issue_valid && !issue_stall && (issue_rd != '0);

    // Set is applied after clear so a new producer overrides a completing write.
    always_comb begin
        busy_next = busy;
        if (wr_en_q) begin
            busy_next[rf_input_select] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector table plus randomized model check
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, lsu_valid, issue_valid;
    logic [4:0]  alu_rd, lsu_rd, issue_rd, issue_rs1, issue_rs2;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, issue_stall, rf_input_enable;
    logic [4:0]  rf_input_select;
    logic [31:0] rf_input_value;
    logic [31:0] busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .lsu_valid       (lsu_valid),
        .lsu_rd          (lsu_rd),
        .lsu_data        (lsu_data),
        .lsu_ready       (lsu_ready),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_rs1       (issue_rs1),
        .issue_rs2       (issue_rs2),
        .issue_stall     (issue_stall),
        .rf_input_enable (rf_input_enable),
        .rf_input_select (rf_input_select),
        .rf_input_value  (rf_input_value),
        .busy            (busy)
    );

    typedef struct {
        bit        rst;
        bit        av;
        bit [4:0]  ard;
        bit [31:0] ad;
        bit        lv;
        bit [4:0]  lrd;
        bit [31:0] ld;
        bit        iv;
        bit [4:0]  ird;
        bit [4:0]  irs1;
        bit [4:0]  irs2;
        bit        ear;
        bit        elr;
        bit        estall;
        bit        een;
        bit [4:0]  esel;
        bit [31:0] eval;
        bit [31:0] ebusy;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit [31:0] m_busy;
    bit        m_pend;
    bit [4:0]  m_sel;
    bit [31:0] m_val;
    bit        m_lsu_won_last;

    function automatic vec_t v(bit rst, bit av, bit [4:0] ard, bit [31:0] ad,
                               bit lv, bit [4:0] lrd, bit [31:0] ld,
                               bit iv, bit [4:0] ird, bit [4:0] irs1, bit [4:0] irs2,
                               bit ear, bit elr, bit estall, bit een,
                               bit [4:0] esel, bit [31:0] eval, bit [31:0] ebusy);
        vec_t r;
        r.rst = rst; r.av = av; r.ard = ard; r.ad = ad;
        r.lv = lv; r.lrd = lrd; r.ld = ld;
        r.iv = iv; r.ird = ird; r.irs1 = irs1; r.irs2 = irs2;
        r.ear = ear; r.elr = elr; r.estall = estall; r.een = een;
        r.esel = esel; r.eval = eval; r.ebusy = ebusy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = '0;
        m_pend = 1'b0;
        m_sel = '0;
        m_val = '0;
        m_lsu_won_last = 1'b1;
    endtask

    // Drive one cycle, compare mid-cycle against the model (and the table row when given),
    // then advance the model across the rising edge.
    task automatic step(input vec_t t, input bit use_tbl);
        bit ear, elr, estall, een, fire, acc;
        bit [4:0]  rd;
        bit [31:0] data, nb;
        rst_n = t.rst;
        alu_valid = t.av; alu_rd = t.ard; alu_data = t.ad;
        lsu_valid = t.lv; lsu_rd = t.lrd; lsu_data = t.ld;
        issue_valid = t.iv; issue_rd = t.ird; issue_rs1 = t.irs1; issue_rs2 = t.irs2;
        #4;
        ear = 1'b0;
        elr = 1'b0;
        if (t.rst) begin
            if (t.av && t.lv) begin
                ear = m_lsu_won_last;
                elr = !m_lsu_won_last;
            end else begin
                ear = t.av;
                elr = t.lv;
            end
        end
        estall = !t.rst || (t.iv && (m_busy[t.irs1] || m_busy[t.irs2] || m_busy[t.ird]));
        een    = t.rst && m_pend;
        chk("model alu_ready", 32'(alu_ready), 32'(ear));
        chk("model lsu_ready", 32'(lsu_ready), 32'(elr));
        chk("model issue_stall", 32'(issue_stall), 32'(estall));
        chk("model rf_enable", 32'(rf_input_enable), 32'(een));
        chk("model rf_select", 32'(rf_input_select), 32'(m_sel));
        chk("model rf_value", rf_input_value, m_val);
        chk("model busy", busy, m_busy);
        if (use_tbl) begin
            chk("vec alu_ready", 32'(alu_ready), 32'(t.ear));
            chk("vec lsu_ready", 32'(lsu_ready), 32'(t.elr));
            chk("vec issue_stall", 32'(issue_stall), 32'(t.estall));
            chk("vec rf_enable", 32'(rf_input_enable), 32'(t.een));
            chk("vec rf_select", 32'(rf_input_select), 32'(t.esel));
            chk("vec rf_value", rf_input_value, t.eval);
            chk("vec busy", busy, t.ebusy);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!t.rst) begin
            model_reset();
        end else begin
            nb = m_busy;
            if (m_pend) nb[m_sel] = 1'b0;
            fire = t.iv && !estall && (t.ird != 0);
            if (fire) nb[t.ird] = 1'b1;
            nb[0] = 1'b0;
            m_busy = nb;
            acc  = ear || elr;
            rd   = ear ? t.ard : t.lrd;
            data = ear ? t.ad : t.ld;
            m_pend = acc && (rd != 0);
            if (m_pend) begin
                m_sel = rd;
                m_val = data;
            end
            if (t.av && t.lv) m_lsu_won_last = elr;
        end
    endtask

    vec_t tbl[24];
    vec_t rv;

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        tbl[0]  = v(0, 1,1,32'h1234,     0,0,0,            0,0,0,0, 0,0,1,0, 0,32'h0,32'h0);
        tbl[1]  = v(1, 0,0,0,            0,0,0,            1,1,0,0, 0,0,0,0, 0,32'h0,32'h0);
        tbl[2]  = v(1, 1,1,32'h3f3f3f3f, 0,0,0,            0,0,0,0, 1,0,0,0, 0,32'h0,32'h2);
        tbl[3]  = v(1, 0,0,0,            0,0,0,            0,0,0,0, 0,0,0,1, 1,32'h3f3f3f3f,32'h2);
        tbl[4]  = v(1, 0,0,0,            0,0,0,            0,0,0,0, 0,0,0,0, 1,32'h3f3f3f3f,32'h0);
        tbl[5]  = v(1, 1,2,32'h11110005, 1,3,32'h22220005, 0,0,0,0, 1,0,0,0, 1,32'h3f3f3f3f,32'h0);
        tbl[6]  = v(1, 1,2,32'h11110006, 1,3,32'h22220006, 0,0,0,0, 0,1,0,1, 2,32'h11110005,32'h0);
        tbl[7]  = v(1, 1,2,32'h11110007, 1,3,32'h22220007, 0,0,0,0, 1,0,0,1, 3,32'h22220006,32'h0);
        tbl[8]  = v(1, 1,2,32'h11110008, 1,3,32'h22220008, 0,0,0,0, 0,1,0,1, 2,32'h11110007,32'h0);
        tbl[9]  = v(1, 0,0,0,            0,0,0,            1,3,0,0, 0,0,0,1, 3,32'h22220008,32'h0);
        tbl[10] = v(1, 1,3,32'h33333333, 0,0,0,            1,4,3,0, 1,0,1,0, 3,32'h22220008,32'h8);
        tbl[11] = v(1, 0,0,0,            0,0,0,            1,4,3,0, 0,0,1,1, 3,32'h33333333,32'h8);
        tbl[12] = v(1, 0,0,0,            0,0,0,            1,4,3,0, 0,0,0,0, 3,32'h33333333,32'h0);
        tbl[13] = v(1, 0,0,0,            1,0,32'hffffffff, 0,0,0,0, 0,1,0,0, 3,32'h33333333,32'h10);
        tbl[14] = v(1, 0,0,0,            0,0,0,            0,0,0,0, 0,0,0,0, 3,32'h33333333,32'h10);
        tbl[15] = v(1, 1,5,32'h55555555, 0,0,0,            0,0,0,0, 1,0,0,0, 3,32'h33333333,32'h10);
        tbl[16] = v(1, 0,0,0,            0,0,0,            1,5,0,0, 0,0,0,1, 5,32'h55555555,32'h10);
        tbl[17] = v(0, 0,0,0,            0,0,0,            0,0,0,0, 0,0,1,0, 5,32'h55555555,32'h30);
        tbl[18] = v(1, 0,0,0,            0,0,0,            1,1,0,0, 0,0,0,0, 0,32'h0,32'h0);
        tbl[19] = v(1, 1,1,32'h77777777, 1,9,32'h99999999, 1,2,0,0, 1,0,0,0, 0,32'h0,32'h2);
        tbl[20] = v(0, 1,2,32'h88888888, 1,3,32'h12345678, 0,0,0,0, 0,0,1,0, 1,32'h77777777,32'h6);
        tbl[21] = v(1, 0,0,0,            0,0,0,            0,0,0,0, 0,0,0,0, 0,32'h0,32'h0);
        tbl[22] = v(1, 1,6,32'h66666666, 1,7,32'h77770007, 0,0,0,0, 1,0,0,0, 0,32'h0,32'h0);
        tbl[23] = v(1, 0,0,0,            0,0,0,            0,0,0,0, 0,0,0,1, 6,32'h66666666,32'h0);

        for (int i = 0; i < 24; i++) begin
            step(tbl[i], 1'b1);
        end

        for (int i = 0; i < 400; i++) begin
            rv = v(($urandom_range(39) != 0),
                   ($urandom_range(1) == 1), 5'($urandom_range(7)), $urandom,
                   ($urandom_range(1) == 1), 5'($urandom_range(7)), $urandom,
                   ($urandom_range(1) == 1), 5'($urandom_range(7)),
                   5'($urandom_range(7)), 5'($urandom_range(7)),
                   0, 0, 0, 0, 0, 0, 0);
            step(rv, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have ports alu_valid (in, 1), alu_rd (in, 5) and alu_data (in, 32): ALU writeback request.
REQ-004 SHALL have port alu_ready, out, 1 bit: ALU request is accepted this cycle.
REQ-005 SHALL have ports lsu_valid (in, 1), lsu_rd (in, 5) and lsu_data (in, 32): load-unit writeback request.
REQ-006 SHALL have port lsu_ready, out, 1 bit: LSU request is accepted this cycle.
REQ-007 SHALL have ports issue_valid (in, 1), issue_rd (in, 5), issue_rs1 (in, 5) and issue_rs2 (in, 5): instruction attempting issue.
REQ-008 SHALL have port issue_stall, out, 1 bit: issue blocked by a hazard.
REQ-009 SHALL have ports rf_input_enable (out, 1), rf_input_select (out, 5) and rf_input_value (out, 32): drive the RegisterFile write port.
REQ-010 SHALL have port busy, out, 32 bits: scoreboard, where bit i set means register xi has a pending write.

Function
REQ-011 SHALL transfer a request on valid && ready; ready SHALL be combinational from valid, arbitration state and rst_n only, with no dependency on data or rd.
REQ-012 SHALL grant at most one requester per cycle; when exactly one requester is valid, that requester SHALL be granted.
REQ-013 SHALL arbitrate round-robin when both are valid: grant the requester not granted at the last contended grant; after reset, ALU wins the first contention.
REQ-014 SHALL update the round-robin pointer only on a contended grant (both valid).
REQ-015 SHALL register the accepted request: accept at edge N -> rf_input_enable=1 with rd/data on rf_input_select/rf_input_value during cycle N+1, so the RegisterFile writes at edge N+1.
REQ-016 SHALL hold rf_input_enable=0 in every cycle without an accepted transfer at the preceding edge; rf_input_select/rf_input_value SHALL hold their last values.
REQ-017 SHALL accept a request with rd=0 (ready behaves normally) but SHALL NOT assert rf_input_enable for it.
REQ-018 SHALL sustain one write per cycle with no bubbles between back-to-back grants.
REQ-019 SHALL compute issue_stall = issue_valid && (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd]) combinationally (RAW and WAW).
REQ-020 SHALL set busy[issue_rd] at the edge where issue_valid && !issue_stall && issue_rd!=0.
REQ-021 SHALL clear busy[rd] at the same edge the RegisterFile write for rd occurs (edge N+1 of REQ-015).
REQ-022 SHALL give set priority when a set and a clear hit the same register at the same edge (the new producer wins).
REQ-023 SHALL keep busy[0] constantly 0.
REQ-024 SHALL leave busy unchanged on writebacks to a non-busy register; this is legal.

Reset
REQ-025 SHALL, while rst_n=0 at a rising edge, clear busy to 0, rf_input_enable/select/value to 0, and the round-robin pointer to ALU-first.
REQ-026 SHALL force alu_ready=0, lsu_ready=0 and issue_stall=1 combinationally while rst_n=0.
REQ-027 SHALL discard any transfer accepted at the edge before reset: no write is issued after reset is asserted mid-operation.

Structure
REQ-028 SHALL take XLEN=32, REG_ADDR_W=5 and NUM_REGS=32 and a requester enum (REQ_ALU, REQ_LSU) from shared package regfile_pkg.
REQ-029 SHALL isolate the two-way round-robin grant logic and pointer in sub-module rr_arbiter.

Verification
REQ-030 SHALL cover this case: ALU-only valid, rd=1, data 'h3f3f3f3f -> alu_ready=1; next cycle rf_input_enable=1, select=1, value 'h3f3f3f3f; busy[1] clears at that edge.
REQ-031 SHALL cover this case: ALU and LSU both valid for 4 cycles after reset -> grants alternate ALU, LSU, ALU, LSU with 4 consecutive writes.
REQ-032 SHALL cover this case: issue rd=3 accepted, then issue rs1=3 -> issue_stall=1 until the cycle after the x3 write appears on the rf port, then 0.
REQ-033 SHALL cover this case: writeback to rd=0 with data 'hffffffff -> ready=1, rf_input_enable stays 0, busy stays 0.
REQ-034 SHALL cover this case: same edge as a pending x5 write completes, issue rd=5 is accepted -> busy[5]=1 afterwards.
REQ-035 SHALL cover this case: rst_n=0 the cycle after an accept with busy='h0000_0006 -> no rf write, busy=0, readies 0 during reset.
